// File: rtl/ip_rx_pkg.sv
// Shared state encoding, header offsets and constants for the IPv4 receive parser.
package ip_rx_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, HEAD, CHK, WORK, REST, DROP, DONE} state_e;

  localparam int unsigned OFF_VER    = 0;
  localparam int unsigned OFF_LEN_HI = 2;
  localparam int unsigned OFF_LEN_LO = 3;
  localparam int unsigned OFF_PROTO  = 9;
  localparam int unsigned OFF_SRC    = 12;
  localparam int unsigned OFF_DST    = 16;

  localparam logic [7:0]  MIN_HLEN = 8'h14;
  localparam logic [7:0]  MIN_DLEN = 8'h2E;
  localparam logic [3:0]  IPV4     = 4'h4;
  localparam logic [31:0] BCAST_IP = 32'hFFFF_FFFF;

  // Ones'-complement add with end-around carry.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum16.sv
// Running 16-bit ones'-complement sum over a byte stream; a halfword is folded in on each
// odd-offset byte.
module ip_csum16 import ip_rx_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_val,
  output logic [15:0] sum
);

  logic       odd;
  logic [7:0] hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odd <= 1'b0;
      hi  <= 8'h00;
      sum <= 16'h0000;
    end else if (clr) begin
      odd <= 1'b0;
      hi  <= 8'h00;
      sum <= 16'h0000;
    end else if (byte_en) begin
      odd <= ~odd;
      if (!odd) hi <= byte_val;
      else      sum <= csum_add(sum, {hi, byte_val});
    end
  end

endmodule

// File: rtl/ip_rx_demux.sv
// IPv4 receive parser: validates the header, filters on destination IP and hands the payload to
// one of NCH protocol channels. Define IP_RX_CSUM_EN to enable header checksum checking.
module ip_rx_demux import ip_rx_pkg::*; #(
  parameter int unsigned      NCH       = 2,
  parameter logic [NCH*8-1:0] PROTO_TAB = {8'h11, 8'h01},  // ch0 = ICMP, ch1 = UDP
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs,
  output logic             fd,
  input  logic [7:0]       rxd,
  input  logic             rxd_en,
  input  logic [31:0]      local_ip,
  output logic [NCH-1:0]   fs_mode,
  input  logic [NCH-1:0]   fd_mode,
  output logic [7:0]       mode_rxd,
  output logic             mode_en,
  output logic [CNT_W-1:0] data_len,
  output logic [7:0]       ip_mode,
  output logic [31:0]      src_ip_addr,
  output logic [31:0]      det_ip_addr,
  output logic             drop,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ver, ihl;
  logic [15:0]      total_len;
  logic [SEL_W-1:0] sel, hit_sel;
  logic [5:0]       hlen, hlen_end;
  logic [15:0]      dlen_calc;
  logic             hit, csum_ok, accept, abort, drop_evt, fwd, head_last, work_last;

  assign hlen      = {ihl, 2'b00};
  // A short IHL still consumes a minimum header so the frame always terminates.
  assign hlen_end  = (ihl < 4'd5) ? 6'(MIN_HLEN) : hlen;
  assign head_last = rxd_en && (cnt == CNT_W'(hlen_end) - CNT_W'(1));
  assign work_last = rxd_en && (cnt == data_len - CNT_W'(1));
  assign dlen_calc = total_len - {10'd0, hlen};

  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (ip_mode == PROTO_TAB[8*i +: 8]) begin
        hit     = 1'b1;
        hit_sel = SEL_W'(i);
      end
    end
  end

`ifdef IP_RX_CSUM_EN
  logic [15:0] csum;

  ip_csum16 u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == WAIT),
    .byte_en  ((state == HEAD) && rxd_en),
    .byte_val (rxd),
    .sum      (csum)
  );

  assign csum_ok = (csum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  assign accept = (ver == IPV4) && (ihl >= 4'd5) && (total_len >= {10'd0, hlen}) &&
                  ((det_ip_addr == local_ip) || (det_ip_addr == BCAST_IP)) && hit && csum_ok;

  assign abort    = !fs && (state inside {HEAD, CHK, WORK});
  assign drop_evt = abort || ((state == CHK) && fs && !accept);
  assign fwd      = (state == WORK) && fs && rxd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = WAIT;
      WAIT: if (fs) state_nxt = HEAD;
      HEAD: begin
        if (!fs)           state_nxt = WAIT;
        else if (head_last) state_nxt = CHK;
      end
      CHK: begin
        if (!fs)                    state_nxt = WAIT;
        else if (!accept)           state_nxt = DROP;
        else if (dlen_calc == '0)   state_nxt = REST;
        else                        state_nxt = WORK;
      end
      WORK: begin
        if (!fs)           state_nxt = WAIT;
        else if (work_last) state_nxt = REST;
      end
      REST: if (fd_mode[sel]) state_nxt = DONE;
      DROP: state_nxt = DONE;
      DONE: if (!fs) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fd      = (state == DONE);
    fs_mode = '0;
    if (state inside {WORK, REST}) fs_mode[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      ver         <= 4'h0;
      ihl         <= 4'h0;
      total_len   <= 16'h0000;
      ip_mode     <= 8'h00;
      src_ip_addr <= 32'h0;
      det_ip_addr <= 32'h0;
      sel         <= '0;
      data_len    <= CNT_W'(MIN_DLEN);
      mode_rxd    <= 8'h00;
      mode_en     <= 1'b0;
      drop        <= 1'b0;
      drop_cnt    <= 16'h0000;
    end else begin
      mode_en  <= fwd;
      mode_rxd <= fwd ? rxd : 8'h00;
      drop     <= drop_evt;
      if (drop_evt && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      if (state inside {WAIT, CHK})                  cnt <= '0;
      else if (rxd_en && (state inside {HEAD, WORK})) cnt <= cnt + CNT_W'(1);

      if ((state == HEAD) && rxd_en) begin
        if (cnt == CNT_W'(OFF_VER))    {ver, ihl}       <= rxd;
        if (cnt == CNT_W'(OFF_LEN_HI)) total_len[15:8] <= rxd;
        if (cnt == CNT_W'(OFF_LEN_LO)) total_len[7:0]  <= rxd;
        if (cnt == CNT_W'(OFF_PROTO))  ip_mode         <= rxd;
        if ((cnt >= CNT_W'(OFF_SRC)) && (cnt < CNT_W'(OFF_SRC + 4)))
          src_ip_addr <= {src_ip_addr[23:0], rxd};
        if ((cnt >= CNT_W'(OFF_DST)) && (cnt < CNT_W'(OFF_DST + 4)))
          det_ip_addr <= {det_ip_addr[23:0], rxd};
      end

      if ((state == CHK) && fs && accept) begin
        sel      <= hit_sel;
        data_len <= CNT_W'(dlen_calc);
      end
    end
  end

endmodule

// File: tb/tb_ip_rx_demux.sv
// Self-checking bench for ip_rx_demux: directed and randomized frames against a byte-level
// reference model of the IPv4 acceptance rules.
module tb_ip_rx_demux;

  localparam int NCH = 2;
  localparam logic [31:0] LOCAL_IP = 32'hC0A8_010A;

  logic            clk = 1'b0, rst = 1'b1, fs = 1'b0, rxd_en = 1'b0;
  logic [7:0]      rxd = 8'h00;
  logic [NCH-1:0]  fd_mode = '0;
  logic            fd, mode_en, drop;
  logic [NCH-1:0]  fs_mode;
  logic [7:0]      mode_rxd, ip_mode;
  logic [15:0]     data_len, drop_cnt;
  logic [31:0]     src_ip_addr, det_ip_addr;

  int n_tests = 0, n_fail = 0;
  logic [7:0] hdr_q[$], pay_q[$], got_pay[$];
  int drop_seen, fd_ok, fd_early;
  logic [NCH-1:0] fs_mode_seen;
  bit exp_acc;
  int exp_sel, exp_dlen, exp_drop_cnt = 0;

  ip_rx_demux #(.NCH(NCH), .PROTO_TAB({8'h11, 8'h01}), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .rxd(rxd), .rxd_en(rxd_en), .local_ip(LOCAL_IP),
    .fs_mode(fs_mode), .fd_mode(fd_mode), .mode_rxd(mode_rxd), .mode_en(mode_en),
    .data_len(data_len), .ip_mode(ip_mode), .src_ip_addr(src_ip_addr),
    .det_ip_addr(det_ip_addr), .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mode_en) got_pay.push_back(mode_rxd);
    if (drop) drop_seen++;
    fs_mode_seen |= fs_mode;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d tests", n_tests);
    $fatal(1);
  end

  task automatic build_frame(input int ihl, input int tlen, input logic [7:0] proto,
                             input logic [31:0] dst, input int corrupt, input int npay);
    logic [31:0] src;
    int s;
    src = $urandom;
    hdr_q.delete();
    pay_q.delete();
    hdr_q.push_back({4'h4, 4'(ihl)}); hdr_q.push_back(8'h00);
    hdr_q.push_back(8'(tlen >> 8));   hdr_q.push_back(8'(tlen));
    hdr_q.push_back(8'($urandom));    hdr_q.push_back(8'($urandom));
    hdr_q.push_back(8'h40);           hdr_q.push_back(8'h00);
    hdr_q.push_back(8'd64);           hdr_q.push_back(proto);
    hdr_q.push_back(8'h00);           hdr_q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) hdr_q.push_back(src[8*i +: 8]);
    for (int i = 3; i >= 0; i--) hdr_q.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 4 * (ihl - 5); i++) hdr_q.push_back(8'($urandom));
    s = 0;
    for (int i = 0; i < hdr_q.size(); i += 2) s += {hdr_q[i], hdr_q[i+1]};
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    s = ~s & 'hFFFF;
    hdr_q[10] = 8'(s >> 8);
    hdr_q[11] = 8'(s) + 8'(corrupt);
    for (int i = 0; i < npay; i++) pay_q.push_back(8'($urandom));
  endtask

  // Reference model: decides acceptance from the raw header bytes.
  task automatic model_frame();
    logic [7:0] b0;
    logic [31:0] dst;
    int ihl, tlen, s;
    b0   = hdr_q[0];
    ihl  = b0[3:0];
    tlen = {hdr_q[2], hdr_q[3]};
    dst  = {hdr_q[16], hdr_q[17], hdr_q[18], hdr_q[19]};
    s = 0;
    for (int i = 0; i + 1 < hdr_q.size(); i += 2) s += {hdr_q[i], hdr_q[i+1]};
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    exp_acc = (b0[7:4] == 4'h4) && (ihl >= 5) && (tlen >= 4 * ihl) &&
              (dst == LOCAL_IP || dst == 32'hFFFF_FFFF) &&
              (hdr_q[9] == 8'h01 || hdr_q[9] == 8'h11);
`ifdef IP_RX_CSUM_EN
    if (s != 'hFFFF) exp_acc = 1'b0;
`endif
    exp_sel  = (hdr_q[9] == 8'h01) ? 0 : 1;
    exp_dlen = tlen - 4 * ihl;
    if (!exp_acc) exp_drop_cnt++;
  endtask

  function automatic int pay_diff(input int n);
    int d;
    d = (got_pay.size() != n) ? 1 : 0;
    foreach (got_pay[i]) if (i < n && got_pay[i] !== pay_q[i]) d++;
    return d;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input int en_pct);
    while ($urandom_range(99) >= en_pct) begin
      rxd_en = 1'b0;
      rxd = 8'($urandom);
      @(negedge clk);
    end
    rxd = b;
    rxd_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input int en_pct, input int ch, input int abort_at, input int rst_at);
    got_pay.delete();
    drop_seen = 0; fs_mode_seen = '0; fd_ok = 0; fd_early = 0;
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    foreach (hdr_q[i]) begin
      if (i == rst_at) begin
        rst = 1'b1; fs = 1'b0; rxd_en = 1'b0;
        #1;
        return;
      end
      drive_byte(hdr_q[i], en_pct);
    end
    rxd_en = 1'b0;
    @(negedge clk);
    foreach (pay_q[i]) begin
      if (i == abort_at) begin
        fs = 1'b0; rxd_en = 1'b0;
        repeat (2) @(negedge clk);
        return;
      end
      drive_byte(pay_q[i], en_pct);
    end
    rxd_en = 1'b0;
    fd_mode = ~(NCH'(1) << ch);
    @(negedge clk);
    fd_early = fd;
    fd_mode = NCH'(1) << ch;
    for (int c = 0; c < 50 && fd_ok == 0; c++) begin
      @(negedge clk);
      if (fd) fd_ok = 1;
    end
    fd_mode = '0;
    fs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({fd, fs_mode, mode_en, mode_rxd, drop, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: fd=%b fs_mode=%b mode_en=%b mode_rxd=%h drop=%b drop_cnt=%0d, want 0",
               fd, fs_mode, mode_en, mode_rxd, drop, drop_cnt);
    end
    n_tests++;
    if (data_len !== 16'h002E) begin
      n_fail++; $display("FAIL reset_data_len: got %h want 002e", data_len);
    end
    n_tests++;
    if ({ip_mode, src_ip_addr, det_ip_addr} !== '0) begin
      n_fail++; $display("FAIL reset_fields: ip_mode=%h src=%h dst=%h want 0", ip_mode, src_ip_addr, det_ip_addr);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_udp();
    build_frame(5, 28, 8'h11, LOCAL_IP, 0, 8);
    model_frame();
    send_frame(100, 1, -1, -1);
    n_tests++;
    if (fs_mode_seen !== 2'b10) begin n_fail++; $display("FAIL udp_fs_mode: got %b want 10", fs_mode_seen); end
    n_tests++;
    if (data_len !== 16'd8) begin n_fail++; $display("FAIL udp_data_len: got %0d want 8", data_len); end
    n_tests++;
    if (pay_diff(8) !== 0) begin n_fail++; $display("FAIL udp_payload: got %0d bytes, want 8 matching", got_pay.size()); end
    n_tests++;
    if (fd_ok !== 1 || fd_early !== 0) begin
      n_fail++; $display("FAIL udp_fd: fd_after_sel=%0d fd_after_other=%0d want 1/0", fd_ok, fd_early);
    end
    n_tests++;
    if (src_ip_addr !== {hdr_q[12], hdr_q[13], hdr_q[14], hdr_q[15]} || ip_mode !== 8'h11) begin
      n_fail++; $display("FAIL udp_fields: src=%h ip_mode=%h", src_ip_addr, ip_mode);
    end
  endtask

  task automatic test_drop_dst();
    build_frame(5, 28, 8'h11, 32'h0A00_0063, 0, 8);
    model_frame();
    send_frame(100, 1, -1, -1);
    n_tests++;
    if (drop_seen !== 1 || drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL dst_drop: pulses=%0d drop_cnt=%0d want 1/1", drop_seen, drop_cnt);
    end
    n_tests++;
    if (fs_mode_seen !== 2'b00 || got_pay.size() !== 0 || fd_ok !== 1) begin
      n_fail++; $display("FAIL dst_quiet: fs_mode=%b bytes=%0d fd=%0d want 00/0/1", fs_mode_seen, got_pay.size(), fd_ok);
    end
  endtask

  task automatic test_options();
    build_frame(6, 32, 8'h01, LOCAL_IP, 0, 8);
    model_frame();
    send_frame(100, 0, -1, -1);
    n_tests++;
    if (fs_mode_seen !== 2'b01 || data_len !== 16'd8) begin
      n_fail++; $display("FAIL opt_accept: fs_mode=%b data_len=%0d want 01/8", fs_mode_seen, data_len);
    end
    n_tests++;
    if (pay_diff(8) !== 0 || det_ip_addr !== LOCAL_IP) begin
      n_fail++; $display("FAIL opt_payload: bytes=%0d dst=%h", got_pay.size(), det_ip_addr);
    end
  endtask

  task automatic test_stall();
    build_frame(5, 28, 8'h11, LOCAL_IP, 0, 8);
    model_frame();
    send_frame(50, 1, -1, -1);
    n_tests++;
    if (pay_diff(8) !== 0 || data_len !== 16'd8 || fs_mode_seen !== 2'b10) begin
      n_fail++; $display("FAIL stall: bytes=%0d data_len=%0d fs_mode=%b", got_pay.size(), data_len, fs_mode_seen);
    end
  endtask

  task automatic test_csum();
    build_frame(5, 28, 8'h11, LOCAL_IP, 1, 8);
    model_frame();
    send_frame(100, 1, -1, -1);
    n_tests++;
    if (drop_seen !== (exp_acc ? 0 : 1) || drop_cnt !== 16'(exp_drop_cnt)) begin
      n_fail++; $display("FAIL csum_bad: pulses=%0d drop_cnt=%0d want %0d/%0d", drop_seen, drop_cnt, exp_acc ? 0 : 1, exp_drop_cnt);
    end
    build_frame(5, 28, 8'h11, 32'hFFFF_FFFF, 0, 8);
    model_frame();
    send_frame(100, 1, -1, -1);
    n_tests++;
    if (drop_seen !== 0 || fs_mode_seen !== 2'b10 || pay_diff(8) !== 0) begin
      n_fail++; $display("FAIL csum_good: pulses=%0d fs_mode=%b bytes=%0d want 0/10/8", drop_seen, fs_mode_seen, got_pay.size());
    end
  endtask

  task automatic test_abort();
    build_frame(5, 28, 8'h11, LOCAL_IP, 0, 8);
    exp_drop_cnt++;
    send_frame(100, 1, 3, -1);
    n_tests++;
    if (got_pay.size() !== 3 || fs_mode !== 2'b00 || fd !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: bytes=%0d fs_mode=%b fd=%b want 3/00/0", got_pay.size(), fs_mode, fd);
    end
    n_tests++;
    if (drop_seen !== 1 || drop_cnt !== 16'(exp_drop_cnt)) begin
      n_fail++; $display("FAIL abort_drop: pulses=%0d drop_cnt=%0d want 1/%0d", drop_seen, drop_cnt, exp_drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    build_frame(5, 28, 8'h11, LOCAL_IP, 0, 8);
    send_frame(100, 1, -1, 10);
    exp_drop_cnt = 0;
    n_tests++;
    if ({fd, fs_mode, mode_en, mode_rxd, drop, drop_cnt, ip_mode, src_ip_addr, det_ip_addr} !== '0 ||
        data_len !== 16'h002E) begin
      n_fail++; $display("FAIL reset_mid: fs_mode=%b drop_cnt=%0d data_len=%h ip_mode=%h src=%h",
                         fs_mode, drop_cnt, data_len, ip_mode, src_ip_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int ihl, dlen, k;
    logic [31:0] dst;
    logic [7:0] proto;
    logic [NCH-1:0] exp_fsm;
    for (int f = 0; f < 12; f++) begin
      ihl  = $urandom_range(7, 5);
      dlen = $urandom_range(12, 0);
      k    = $urandom_range(2, 0);
      dst  = (k == 0) ? LOCAL_IP : (k == 1) ? 32'hFFFF_FFFF : (32'h0A00_0000 | $urandom_range(200, 1));
      k    = $urandom_range(2, 0);
      proto = (k == 0) ? 8'h01 : (k == 1) ? 8'h11 : 8'h06;
      build_frame(ihl, 4 * ihl + dlen, proto, dst, ($urandom_range(3, 0) == 0) ? 1 : 0, dlen);
      model_frame();
      send_frame(($urandom_range(1, 0) == 1) ? 60 : 100, exp_sel, -1, -1);
      exp_fsm = exp_acc ? (NCH'(1) << exp_sel) : '0;
      n_tests++;
      if (fs_mode_seen !== exp_fsm || drop_seen !== (exp_acc ? 0 : 1) || drop_cnt !== 16'(exp_drop_cnt)) begin
        n_fail++; $display("FAIL rand%0d_ctl: fs_mode=%b/%b pulses=%0d drop_cnt=%0d/%0d", f,
                           fs_mode_seen, exp_fsm, drop_seen, drop_cnt, exp_drop_cnt);
      end
      n_tests++;
      if (pay_diff(exp_acc ? exp_dlen : 0) !== 0 || fd_ok !== 1 ||
          (exp_acc && data_len !== 16'(exp_dlen))) begin
        n_fail++; $display("FAIL rand%0d_data: bytes=%0d data_len=%0d want %0d fd=%0d", f,
                           got_pay.size(), data_len, exp_dlen, fd_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_udp();
    test_drop_dst();
    test_options();
    test_stall();
    test_csum();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
